data_mem_arbiter: RTL and testbench

//   Shares the single-port data memory between two requesters: port 0 is the core load/store stage and port 1 is the program/debug loader.

---
 rtl/data_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory (port 0 = load/store, port 1 = loader).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 always wins a tie.

module data_mem_arbiter_rport #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= load;
            if (load) rdata <= din;
        end
    end
endmodule

module data_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int NUM_PORTS = 2;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t                           state, state_nx;
    logic [CNT_W-1:0]                 cnt, cnt_nx;
    logic                             win, pick, tie_win, acc_we, take, cap;
    logic [NUM_PORTS-1:0]             req, we_v, gnt_v, rvalid_v;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_v;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_v, rdata_v;

    assign req     = {r1_req, r0_req};
    assign we_v    = {r1_we, r0_we};
    assign addr_v  = {r1_addr, r0_addr};
    assign wdata_v = {r1_wdata, r0_wdata};

`ifdef MEM_ARB_RR_EN
    // Remembers the most recent grantee; a tie goes to the other port.
    logic last_gnt;

    always_ff @(posedge clk) begin
        if (reset)                 last_gnt <= 1'b1;
        else if (state == ACCESS)  last_gnt <= win;
    end

    assign tie_win = ~last_gnt;
`else
    assign tie_win = 1'b0;
`endif

    assign pick = (&req) ? tie_win : req[1];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        take     = 1'b0;
        cap      = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    take     = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (acc_we) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = CNT_W'(MEM_LAT);
                end
            end
            WAIT: begin
                cnt_nx = cnt - 1'b1;
                // Data is valid on mem_rdata during the last WAIT cycle.
                if (cnt == CNT_W'(1)) begin
                    cap      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            win       <= 1'b0;
            acc_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (take) begin
                win       <= pick;
                acc_we    <= we_v[pick];
                mem_addr  <= addr_v[pick];
                mem_wdata <= wdata_v[pick];
            end
        end
    end

    always_comb begin
        gnt_v = '0;
        if (state == ACCESS) gnt_v[win] = 1'b1;
    end

    assign mem_we = (state == ACCESS) && acc_we;
    assign mem_re = (state == ACCESS) && !acc_we;
    assign busy   = (state != IDLE);
    assign r0_gnt = gnt_v[0];
    assign r1_gnt = gnt_v[1];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rport
        data_mem_arbiter_rport #(
            .DATA_W(DATA_W)
        ) u_rport (
            .clk   (clk),
            .reset (reset),
            .load  (cap && (win == 1'(p))),
            .din   (mem_rdata),
            .rvalid(rvalid_v[p]),
            .rdata (rdata_v[p])
        );
    end

    assign r0_rvalid = rvalid_v[0];
    assign r1_rvalid = rvalid_v[1];
    assign r0_rdata  = rdata_v[0];
    assign r1_rdata  = rdata_v[1];
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed scenarios plus random two-port traffic.
// The reference model tracks memory contents, arbiter occupancy and tie-break order abstractly.

module tb_data_mem_arbiter;
    localparam int LAT = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gap;
    } txn_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rd_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req_v = '0, we_v = '0;
    logic [1:0][31:0] addr_v = '0, wdata_v = '0;
    logic             r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we, mem_re, busy;
    logic [31:0]      r0_rdata, r1_rdata, mem_addr, mem_wdata, mem_rdata;

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .r0_req(req_v[0]), .r0_we(we_v[0]), .r0_addr(addr_v[0]), .r0_wdata(wdata_v[0]),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(req_v[1]), .r1_we(we_v[1]), .r1_addr(addr_v[1]), .r1_wdata(wdata_v[1]),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: data appears LAT cycles after the mem_re cycle, junk otherwise.
    logic [31:0]    sram [logic [31:0]];
    logic [LAT-1:0] pv = '0;
    logic [31:0]    pd [LAT];
    logic [31:0]    junk = 32'h0;

    always @(posedge clk) begin
        junk <= $urandom;
        if (mem_we) sram[mem_addr] = mem_wdata;
        pv    <= {pv[LAT-2:0], mem_re};
        pd[0] <= sram.exists(mem_addr) ? sram[mem_addr] : 32'h0;
        for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
    end
    assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : junk;

    txn_t        stim_q [2][$];
    txn_t        pend_q [2][$];
    rd_t         rd_q   [2][$];
    logic [31:0] ref_mem [logic [31:0]];
    int          n_chk = 0, n_fail = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void fail_now(string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endfunction

    // Model state
    int          free_at = 0;
    int          last_gnt = 1;
    bit          prev_free = 1'b1, prev_reset = 1'b1, now_free;
    logic [1:0]  prev_req = '0;
    logic [31:0] exp_rdata [2] = '{32'h0, 32'h0};
    logic [31:0] last_addr = 32'h0;

    always @(negedge clk) begin
        bit          g;
        int          w;
        logic [1:0]  gv;
        txn_t        x;
        logic        rv;
        logic [31:0] rd;

        g = prev_free && !prev_reset && (prev_req != 2'b00);
        if (prev_req == 2'b11) begin
`ifdef MEM_ARB_RR_EN
            w = (last_gnt == 0) ? 1 : 0;
`else
            w = 0;
`endif
        end else begin
            w = prev_req[1] ? 1 : 0;
        end
        gv = 2'b00;
        if (g) gv[w] = 1'b1;
        chk("gnt", 64'({r1_gnt, r0_gnt}), 64'(gv));

        if (prev_reset) chk("reset_mem_wdata", 64'(mem_wdata), 64'h0);

        if (g) begin
            if (pend_q[w].size() == 0) begin
                fail_now("gnt_without_pending_request");
            end else begin
                x = pend_q[w].pop_front();
                chk("mem_we", 64'(mem_we), 64'(x.we));
                chk("mem_re", 64'(mem_re), 64'(!x.we));
                chk("mem_addr", 64'(mem_addr), 64'(x.addr));
                last_addr = x.addr;
                if (x.we) begin
                    chk("mem_wdata", 64'(mem_wdata), 64'(x.wdata));
                    ref_mem[x.addr] = x.wdata;
                    free_at = cyc + 1;
                end else begin
                    rd_q[w].push_back('{ref_mem.exists(x.addr) ? ref_mem[x.addr] : 32'h0, cyc + 1 + LAT});
                    free_at = cyc + 1 + LAT;
                end
                last_gnt = w;
            end
        end else begin
            chk("mem_we_idle", 64'(mem_we), 64'h0);
            chk("mem_re_idle", 64'(mem_re), 64'h0);
            chk("mem_addr_hold", 64'(mem_addr), 64'(last_addr));
        end

        for (int p = 0; p < 2; p++) begin
            rv = (p == 1) ? r1_rvalid : r0_rvalid;
            rd = (p == 1) ? r1_rdata : r0_rdata;
            while (rd_q[p].size() > 0 && rd_q[p][0].cyc < cyc) begin
                fail_now($sformatf("r%0d_rvalid_missed", p));
                void'(rd_q[p].pop_front());
            end
            if (rd_q[p].size() > 0 && rd_q[p][0].cyc == cyc) begin
                chk($sformatf("r%0d_rvalid", p), 64'(rv), 64'h1);
                chk($sformatf("r%0d_rdata", p), 64'(rd), 64'(rd_q[p][0].data));
                exp_rdata[p] = rd_q[p][0].data;
                void'(rd_q[p].pop_front());
            end else begin
                chk($sformatf("r%0d_rvalid_idle", p), 64'(rv), 64'h0);
                chk($sformatf("r%0d_rdata_hold", p), 64'(rd), 64'(exp_rdata[p]));
            end
        end

        now_free = (cyc >= free_at);
        chk("busy", 64'(busy), 64'(!now_free));

        prev_req   = req_v;
        prev_free  = now_free;
        prev_reset = reset;
        if (reset) begin
            free_at   = 0;
            prev_free = 1'b1;
            rd_q[0].delete();
            rd_q[1].delete();
            exp_rdata = '{32'h0, 32'h0};
            last_addr = 32'h0;
            last_gnt  = 1;
        end
    end

    // Requester driver: holds each request until its grant is seen.
    initial begin
        bit         hold [2] = '{1'b0, 1'b0};
        int         gap_c [2] = '{-1, -1};
        int         wait_c [2] = '{0, 0};
        logic [1:0] g;
        txn_t       x;
        forever begin
            @(negedge clk);
            g = {r1_gnt, r0_gnt};
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (hold[p] && g[p]) begin
                    hold[p]  = 1'b0;
                    req_v[p] = 1'b0;
                end
                if (hold[p]) begin
                    wait_c[p]++;
                    if (wait_c[p] > 300) begin
                        fail_now($sformatf("r%0d_gnt_timeout", p));
                        hold[p]  = 1'b0;
                        req_v[p] = 1'b0;
                        void'(pend_q[p].pop_back());
                    end
                end else if (stim_q[p].size() > 0) begin
                    if (gap_c[p] < 0) gap_c[p] = stim_q[p][0].gap;
                    if (gap_c[p] > 0) begin
                        gap_c[p]--;
                    end else begin
                        gap_c[p]   = -1;
                        x          = stim_q[p].pop_front();
                        req_v[p]   = 1'b1;
                        we_v[p]    = x.we;
                        addr_v[p]  = x.addr;
                        wdata_v[p] = x.wdata;
                        pend_q[p].push_back(x);
                        hold[p]    = 1'b1;
                        wait_c[p]  = 0;
                    end
                end
            end
        end
    end

    task automatic push(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gap);
        stim_q[p].push_back('{we: we, addr: addr, wdata: wdata, gap: gap});
    endtask

    task automatic drain();
        int n = 0;
        while ((stim_q[0].size() + stim_q[1].size() + pend_q[0].size() + pend_q[1].size()
                + rd_q[0].size() + rd_q[1].size() != 0 || req_v != 2'b00 || busy) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) fail_now("drain_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single write, then a read of the same word from the other port.
        push(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        drain();
        push(1, 1'b0, 32'h10, 32'h0, 0);
        drain();

        // Both ports issuing reads back-to-back exercise the tie-break.
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 32'h10, 32'h0, 0);
            push(1, 1'b0, 32'h10, 32'h0, 0);
        end
        drain();

        // Reset while a port 0 read is in its latency wait.
        push(0, 1'b0, 32'h10, 32'h0, 0);
        n = 0;
        while (!r0_gnt && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("reset_test_gnt_timeout");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        push(0, 1'b1, 32'h20, 32'h12345678, 0);
        push(0, 1'b0, 32'h20, 32'h0, 0);
        drain();

        // Long read on port 0 while a port 1 write waits behind it.
        push(0, 1'b0, 32'h20, 32'h0, 0);
        push(1, 1'b1, 32'h24, 32'hCAFEF00D, 1);
        drain();

        // Random two-port traffic.
        for (int i = 0; i < 60; i++) begin
            for (int p = 0; p < 2; p++) begin
                push(p, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4),
                     32'($urandom), int'($urandom_range(0, 3)));
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        fail_now("global_timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "simulation time limit reached");
    end
endmodule
